axi_ds_compl_responder: RTL

// - AXI4 subordinate (responder) on the IOMMU downstream translation-completion port.
// - Accepts AR/AW from the IOMMU and returns in-order R bursts and B responses.
// - Backed by a small word-addressed memory; used as the sim/formal counterpart of the master-side protocol checks.
// - Outstanding transactions are buffered per channel; responses are never interleaved.

---
 rtl/axi_ds_compl_responder_pkg.sv | 39 +++
 rtl/axi_ds_compl_responder_if.sv | 56 +++++
 rtl/axi_ds_compl_responder_fifo.sv | 53 +++++
 rtl/axi_ds_compl_responder.sv | 131 +++++++++++++
 4 files changed

// File: rtl/axi_ds_compl_responder_pkg.sv
// Shared types and constants for the downstream completion responder.
// Holds queue entry structs, AXI response codes and a byte-strobe helper.
package axi_resp_pkg;

    localparam int ID_W       = 4;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 64;
    localparam int STRB_W     = 8;
    localparam int LEN_W      = 8;
    localparam int BEAT_BYTES = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } ar_entry_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_entry_t;

    function automatic logic [DATA_W-1:0] strb_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_ds_compl_responder_if.sv
// AXI4 AR/AW/W/R/B signal bundle between the IOMMU master and the responder.
// Modports: master drives requests and ready for R/B, slave the reverse.
interface axi_ds_compl_responder_if;
    import axi_resp_pkg::*;

    logic              ar_valid;
    logic              ar_ready;
    logic [ID_W-1:0]   ar_id;
    logic [ADDR_W-1:0] ar_addr;
    logic [LEN_W-1:0]  ar_len;

    logic              aw_valid;
    logic              aw_ready;
    logic [ID_W-1:0]   aw_id;
    logic [ADDR_W-1:0] aw_addr;
    logic [LEN_W-1:0]  aw_len;

    logic              w_valid;
    logic              w_ready;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic              w_last;

    logic              r_valid;
    logic              r_ready;
    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_last;

    logic              b_valid;
    logic              b_ready;
    logic [ID_W-1:0]   b_id;
    logic [1:0]        b_resp;

    modport slave (
        input  ar_valid, ar_id, ar_addr, ar_len,
        input  aw_valid, aw_id, aw_addr, aw_len,
        input  w_valid, w_data, w_strb, w_last,
        input  r_ready, b_ready,
        output ar_ready, aw_ready, w_ready,
        output r_valid, r_id, r_data, r_resp, r_last,
        output b_valid, b_id, b_resp
    );

    modport master (
        output ar_valid, ar_id, ar_addr, ar_len,
        output aw_valid, aw_id, aw_addr, aw_len,
        output w_valid, w_data, w_strb, w_last,
        output r_ready, b_ready,
        input  ar_ready, aw_ready, w_ready,
        input  r_valid, r_id, r_data, r_resp, r_last,
        input  b_valid, b_id, b_resp
    );

endinterface

// File: rtl/axi_ds_compl_responder_fifo.sv
// First-word-fall-through FIFO used for the AR, AW and B queues.
// Ports: clk_i, rst_ni, push/din, pop/dout, full, empty.
module resp_fifo #(
    parameter int  DEPTH_BITS = 3,
    parameter type T          = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    T                    mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wr_q;
    logic [DEPTH_BITS-1:0] rd_q;
    logic [DEPTH_BITS:0]   cnt_q;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (cnt_q == (DEPTH_BITS+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    // A full queue refuses a push even when it is popped in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/axi_ds_compl_responder.sv
// AXI4 responder for the IOMMU downstream completion port, backed by a
// word memory. Ports: clk_i, rst_ni, axi (slave modport of the AXI bundle).
module axi_ds_compl_responder
    import axi_resp_pkg::*;
#(
    parameter int DEPTH_BITS = 3,
    parameter int MEM_AW     = 4
) (
    input logic                       clk_i,
    input logic                       rst_ni,
    axi_ds_compl_responder_if.slave   axi
);

    localparam int WORDS = 1 << MEM_AW;

    logic [DATA_W-1:0] mem_q [WORDS];

    ar_entry_t ar_in, ar_head;
    ar_entry_t aw_in, aw_head;
    b_entry_t  b_in, b_head;

    logic ar_full, ar_empty;
    logic aw_full, aw_empty;
    logic b_full, b_empty;

    logic [LEN_W-1:0]  rbeat_q, wbeat_q;
    logic [MEM_AW-1:0] r_idx, w_idx;
    logic [DATA_W-1:0] r_word, r_data, r_hold_q;
    logic              r_stall_q;
    logic              r_valid, r_last, r_hs;
    logic              w_ready, w_hs, w_done;

    assign ar_in = '{id: axi.ar_id, addr: axi.ar_addr, len: axi.ar_len};
    assign aw_in = '{id: axi.aw_id, addr: axi.aw_addr, len: axi.aw_len};

    resp_fifo #(.DEPTH_BITS(DEPTH_BITS), .T(ar_entry_t)) u_ar_q (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .push  (axi.ar_valid),
        .din   (ar_in),
        .pop   (r_hs && r_last),
        .dout  (ar_head),
        .full  (ar_full),
        .empty (ar_empty)
    );

    resp_fifo #(.DEPTH_BITS(DEPTH_BITS), .T(ar_entry_t)) u_aw_q (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .push  (axi.aw_valid),
        .din   (aw_in),
        .pop   (w_done),
        .dout  (aw_head),
        .full  (aw_full),
        .empty (aw_empty)
    );

    resp_fifo #(.DEPTH_BITS(DEPTH_BITS), .T(b_entry_t)) u_b_q (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .push  (w_done),
        .din   (b_in),
        .pop   (axi.b_ready),
        .dout  (b_head),
        .full  (b_full),
        .empty (b_empty)
    );

    assign axi.ar_ready = !ar_full;
    assign axi.aw_ready = !aw_full;

    // Read path: the queue head is served beat by beat, index wraps.
    assign r_valid = !ar_empty;
    assign r_last  = (rbeat_q == ar_head.len);
    assign r_hs    = r_valid && axi.r_ready;
    assign r_idx   = ar_head.addr[MEM_AW+2:3] + rbeat_q[MEM_AW-1:0];
    assign r_word  = mem_q[r_idx];
    // A write landing on the stalled word must not disturb the beat on show.
    assign r_data  = r_stall_q ? r_hold_q : r_word;

    assign axi.r_valid = r_valid;
    assign axi.r_id    = ar_head.id;
    assign axi.r_data  = r_data;
    assign axi.r_resp  = RESP_OKAY;
    assign axi.r_last  = r_last;

    // Write path: W is accepted only with its AW queued and room for the B.
    assign w_ready = !aw_empty && !b_full;
    assign w_hs    = axi.w_valid && w_ready;
    assign w_done  = w_hs && axi.w_last;
    assign w_idx   = aw_head.addr[MEM_AW+2:3] + wbeat_q[MEM_AW-1:0];
    assign b_in    = '{id:   aw_head.id,
                       resp: (wbeat_q == aw_head.len) ? RESP_OKAY
                                                      : RESP_SLVERR};

    assign axi.w_ready = w_ready;
    assign axi.b_valid = !b_empty;
    assign axi.b_id    = b_head.id;
    assign axi.b_resp  = b_head.resp;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rbeat_q   <= '0;
            wbeat_q   <= '0;
            r_stall_q <= 1'b0;
            r_hold_q  <= '0;
        end else begin
            r_stall_q <= r_valid && !axi.r_ready;
            r_hold_q  <= r_data;
            if (r_hs) rbeat_q <= r_last ? '0 : rbeat_q + 8'd1;
            if (w_hs) wbeat_q <= axi.w_last ? '0 : wbeat_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
        end else if (w_hs) begin
            mem_q[w_idx] <= strb_merge(mem_q[w_idx], axi.w_data, axi.w_strb);
        end
    end

    logic unused_bits;
    assign unused_bits = ^{ar_head.addr[ADDR_W-1:MEM_AW+3],
                           ar_head.addr[2:0],
                           aw_head.addr[ADDR_W-1:MEM_AW+3],
                           aw_head.addr[2:0],
                           rbeat_q[LEN_W-1:MEM_AW],
                           wbeat_q[LEN_W-1:MEM_AW]};

endmodule
